// File: rtl/sap_pkg.sv
// Shared SAP-1+ definitions: default widths, opcodes and control-word bit positions
// so the sequencer and the datapath agree on one encoding.
package sap_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 16;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 4;
  localparam int unsigned CTRL_WIDTH         = 16;

  localparam int unsigned CTRL_HLT     = 15;
  localparam int unsigned CTRL_MAR_IN  = 14;
  localparam int unsigned CTRL_RAM_IN  = 13;
  localparam int unsigned CTRL_RAM_OUT = 12;
  localparam int unsigned CTRL_IR_OUT  = 11;
  localparam int unsigned CTRL_IR_IN   = 10;
  localparam int unsigned CTRL_A_IN    = 9;
  localparam int unsigned CTRL_A_OUT   = 8;
  localparam int unsigned CTRL_ALU_OUT = 7;
  localparam int unsigned CTRL_ALU_SUB = 6;
  localparam int unsigned CTRL_B_IN    = 5;
  localparam int unsigned CTRL_OUT_IN  = 4;
  localparam int unsigned CTRL_PC_INC  = 3;
  localparam int unsigned CTRL_PC_OUT  = 2;
  localparam int unsigned CTRL_PC_JUMP = 1;
  localparam int unsigned CTRL_FR_IN   = 0;

  typedef enum logic [7:0] {
    OpNop = 8'h00,
    OpLda = 8'h01,
    OpAdd = 8'h02,
    OpSub = 8'h03,
    OpSta = 8'h04,
    OpLdi = 8'h05,
    OpJmp = 8'h06,
    OpJc  = 8'h07,
    OpJz  = 8'h08,
    OpOut = 8'h0E,
    OpHlt = 8'h0F
  } opcode_e;

  function automatic opcode_e opcode_of(logic [DEFAULT_DATA_WIDTH-1:0] instr);
    return opcode_e'(instr[15:8]);
  endfunction

endpackage

// File: rtl/sap_ram.sv
// Program/data RAM: one synchronous write port shared by the bus and the host loader,
// asynchronous read at the memory address register.
module sap_ram
  import sap_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  i_clock,
  input  logic                  i_load_en,
  input  logic                  i_load_we,
  input  logic [ADDR_WIDTH-1:0] i_load_addr,
  input  logic [DATA_WIDTH-1:0] i_load_data,
  input  logic                  i_bus_we,
  input  logic [DATA_WIDTH-1:0] i_bus_data,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [DATA_WIDTH-1:0] o_read_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  write_en;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;

  // Host loader owns the port outright while load mode is on.
  always_comb begin
    if (i_load_en) begin
      write_en   = i_load_we;
      write_addr = i_load_addr;
      write_data = i_load_data;
    end else begin
      write_en   = i_bus_we;
      write_addr = i_address;
      write_data = i_bus_data;
    end
  end

  always_ff @(posedge i_clock) begin
    if (write_en) begin
      mem[write_addr] <= write_data;
    end
  end

  assign o_read_data = mem[i_address];

endmodule

// File: rtl/sap_datapath.sv
// SAP-1+ datapath: executes per-cycle control strobes on a shared bus joining RAM, MAR,
// PC, IR, A, B, ALU, flags and the output register.
module sap_datapath
  import sap_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_halt,
  input  logic                  i_memory_address_in,
  input  logic                  i_ram_in,
  input  logic                  i_ram_out,
  input  logic                  i_instruction_in,
  input  logic                  i_instruction_out,
  input  logic                  i_register_a_in,
  input  logic                  i_register_a_out,
  input  logic                  i_alu_out,
  input  logic                  i_alu_subtract,
  input  logic                  i_register_b_in,
  input  logic                  i_register_output_in,
  input  logic                  i_pc_increment,
  input  logic                  i_pc_out,
  input  logic                  i_pc_jump,
  input  logic                  i_register_flags_in,
  input  logic                  i_load_en,
  input  logic                  i_load_we,
  input  logic [ADDR_WIDTH-1:0] i_load_addr,
  input  logic [DATA_WIDTH-1:0] i_load_data,
  output logic [DATA_WIDTH-1:0] o_instruction,
  output logic                  o_flag_overflow,
  output logic                  o_flag_zero,
  output logic [DATA_WIDTH-1:0] o_output,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic [DATA_WIDTH-1:0] o_bus,
  output logic                  o_bus_conflict
);

  logic [DATA_WIDTH-1:0] a_q, b_q, ir_q, out_q;
  logic [ADDR_WIDTH-1:0] mar_q, pc_q;
  logic                  carry_q, zero_q, conflict_q;

  logic [DATA_WIDTH-1:0] bus, ram_rdata, pc_drive, ir_drive;
  logic [DATA_WIDTH-1:0] alu_b, alu_result;
  logic [DATA_WIDTH:0]   alu_sum;
  logic [2:0]            n_drivers;
  logic                  active;

  assign active = !i_load_en && !i_halt;

  sap_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .i_clock     (i_clock),
    .i_load_en   (i_load_en),
    .i_load_we   (i_load_we),
    .i_load_addr (i_load_addr),
    .i_load_data (i_load_data),
    .i_bus_we    (i_ram_in && !i_halt),
    .i_bus_data  (bus),
    .i_address   (mar_q),
    .o_read_data (ram_rdata)
  );

  // Subtract is A + ~B + 1, so carry-out set means no borrow.
  assign alu_b      = i_alu_subtract ? ~b_q : b_q;
  assign alu_sum    = {1'b0, a_q} + {1'b0, alu_b} + {{DATA_WIDTH{1'b0}}, i_alu_subtract};
  assign alu_result = alu_sum[DATA_WIDTH-1:0];

  always_comb begin
    pc_drive                 = '0;
    pc_drive[ADDR_WIDTH-1:0] = pc_q;
    ir_drive                 = '0;
    ir_drive[7:0]            = ir_q[7:0];
  end

  always_comb begin
    bus = '0;
    if (i_pc_out) begin
      bus = pc_drive;
    end else if (i_instruction_out) begin
      bus = ir_drive;
    end else if (i_ram_out) begin
      bus = ram_rdata;
    end else if (i_register_a_out) begin
      bus = a_q;
    end else if (i_alu_out) begin
      bus = alu_result;
    end
  end

  assign n_drivers = 3'(i_pc_out) + 3'(i_instruction_out) + 3'(i_ram_out) +
                     3'(i_register_a_out) + 3'(i_alu_out);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      a_q        <= '0;
      b_q        <= '0;
      ir_q       <= '0;
      out_q      <= '0;
      mar_q      <= '0;
      pc_q       <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else if (active) begin
      if (i_memory_address_in)  mar_q <= bus[ADDR_WIDTH-1:0];
      if (i_instruction_in)     ir_q  <= bus;
      if (i_register_a_in)      a_q   <= bus;
      if (i_register_b_in)      b_q   <= bus;
      if (i_register_output_in) out_q <= bus;
      if (i_pc_jump) begin
        pc_q <= bus[ADDR_WIDTH-1:0];
      end else if (i_pc_increment) begin
        pc_q <= pc_q + 1'b1;
      end
      if (i_register_flags_in) begin
        carry_q <= alu_sum[DATA_WIDTH];
        zero_q  <= (alu_result == '0);
      end
      if (n_drivers > 3'd1) conflict_q <= 1'b1;
    end
  end

  assign o_instruction   = ir_q;
  assign o_flag_overflow = carry_q;
  assign o_flag_zero     = zero_q;
  assign o_output        = out_q;
  assign o_pc            = pc_q;
  assign o_bus           = bus;
  assign o_bus_conflict  = conflict_q;

endmodule

// File: tb/tb_sap_datapath.sv
// Bench for sap_datapath: directed scenarios plus randomized strobes against a behavioural model.
module tb_sap_datapath;
  import sap_pkg::*;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic [15:0] ctrl = '0;
  logic        load_en = 1'b0, load_we = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [15:0] load_data = '0;

  logic [15:0] o_instruction, o_output, o_bus;
  logic        o_flag_overflow, o_flag_zero, o_bus_conflict;
  logic [3:0]  o_pc;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic [15:0] m_a, m_b, m_ir, m_out;
  logic [3:0]  m_mar, m_pc;
  logic        m_c, m_z, m_conf;
  logic [15:0] m_ram [16];
  logic [15:0] seen_bus;

  always #5 i_clock = ~i_clock;

  sap_datapath dut (
    .i_clock              (i_clock),
    .i_reset              (i_reset),
    .i_halt               (ctrl[CTRL_HLT]),
    .i_memory_address_in  (ctrl[CTRL_MAR_IN]),
    .i_ram_in             (ctrl[CTRL_RAM_IN]),
    .i_ram_out            (ctrl[CTRL_RAM_OUT]),
    .i_instruction_in     (ctrl[CTRL_IR_IN]),
    .i_instruction_out    (ctrl[CTRL_IR_OUT]),
    .i_register_a_in      (ctrl[CTRL_A_IN]),
    .i_register_a_out     (ctrl[CTRL_A_OUT]),
    .i_alu_out            (ctrl[CTRL_ALU_OUT]),
    .i_alu_subtract       (ctrl[CTRL_ALU_SUB]),
    .i_register_b_in      (ctrl[CTRL_B_IN]),
    .i_register_output_in (ctrl[CTRL_OUT_IN]),
    .i_pc_increment       (ctrl[CTRL_PC_INC]),
    .i_pc_out             (ctrl[CTRL_PC_OUT]),
    .i_pc_jump            (ctrl[CTRL_PC_JUMP]),
    .i_register_flags_in  (ctrl[CTRL_FR_IN]),
    .i_load_en            (load_en),
    .i_load_we            (load_we),
    .i_load_addr          (load_addr),
    .i_load_data          (load_data),
    .o_instruction        (o_instruction),
    .o_flag_overflow      (o_flag_overflow),
    .o_flag_zero          (o_flag_zero),
    .o_output             (o_output),
    .o_pc                 (o_pc),
    .o_bus                (o_bus),
    .o_bus_conflict       (o_bus_conflict)
  );

  function automatic logic [15:0] bit_of(input int unsigned i);
    return 16'(1) << i;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] alu_model();
    if (ctrl[CTRL_ALU_SUB]) return m_a - m_b;
    return m_a + m_b;
  endfunction

  // Bus value by driver priority, plus how many drivers asked for the bus.
  task automatic calc_bus(output logic [15:0] eb, output int nd);
    logic [15:0] cand [5];
    logic        req  [5];
    cand[0] = 16'(m_pc);               req[0] = ctrl[CTRL_PC_OUT];
    cand[1] = {8'h00, m_ir[7:0]};      req[1] = ctrl[CTRL_IR_OUT];
    cand[2] = m_ram[m_mar];            req[2] = ctrl[CTRL_RAM_OUT];
    cand[3] = m_a;                     req[3] = ctrl[CTRL_A_OUT];
    cand[4] = alu_model();             req[4] = ctrl[CTRL_ALU_OUT];
    eb = '0;
    nd = 0;
    for (int i = 4; i >= 0; i--) begin
      if (req[i]) begin
        eb = cand[i];
        nd++;
      end
    end
  endtask

  task automatic model_step(input logic [15:0] eb, input int nd);
    logic [15:0] r;
    if (load_en) begin
      if (load_we) m_ram[load_addr] = load_data;
    end else if (!ctrl[CTRL_HLT]) begin
      r = alu_model();
      if (ctrl[CTRL_FR_IN]) begin
        m_c = ctrl[CTRL_ALU_SUB] ? (m_a >= m_b) : ((int'(m_a) + int'(m_b)) > 65535);
        m_z = (r == 16'h0);
      end
      if (ctrl[CTRL_RAM_IN]) m_ram[m_mar] = eb;
      if (ctrl[CTRL_MAR_IN]) m_mar = eb[3:0];
      if (ctrl[CTRL_IR_IN])  m_ir  = eb;
      if (ctrl[CTRL_A_IN])   m_a   = eb;
      if (ctrl[CTRL_B_IN])   m_b   = eb;
      if (ctrl[CTRL_OUT_IN]) m_out = eb;
      if (ctrl[CTRL_PC_JUMP])     m_pc = eb[3:0];
      else if (ctrl[CTRL_PC_INC]) m_pc = m_pc + 4'd1;
      if (nd > 1) m_conf = 1'b1;
    end
  endtask

  task automatic check_regs();
    check("instruction", o_instruction, m_ir);
    check("output", o_output, m_out);
    check("pc", o_pc, m_pc);
    check("flag_overflow", o_flag_overflow, m_c);
    check("flag_zero", o_flag_zero, m_z);
    check("bus_conflict", o_bus_conflict, m_conf);
  endtask

  // Called 1ns after a posedge; leaves the bench 1ns after the next posedge.
  task automatic tick(input logic [15:0] c);
    logic [15:0] eb;
    int          nd;
    ctrl = c;
    #1;
    calc_bus(eb, nd);
    seen_bus = o_bus;
    check("bus", o_bus, eb);
    model_step(eb, nd);
    @(posedge i_clock);
    #1;
    check_regs();
  endtask

  task automatic host_write(input logic [3:0] addr, input logic [15:0] data,
                            input logic [15:0] c);
    load_en   = 1'b1;
    load_we   = 1'b1;
    load_addr = addr;
    load_data = data;
    tick(c);
    load_en = 1'b0;
    load_we = 1'b0;
  endtask

  // Place a value on the bus through RAM[MAR] and latch it with one strobe.
  task automatic put(input logic [15:0] v, input int unsigned dest);
    host_write(m_mar, v, 16'h0);
    tick(bit_of(CTRL_RAM_OUT) | bit_of(dest));
  endtask

  task automatic do_reset();
    ctrl    = '0;
    i_reset = 1'b1;
    #1;
    m_a = '0; m_b = '0; m_ir = '0; m_out = '0;
    m_mar = '0; m_pc = '0; m_c = 1'b0; m_z = 1'b0; m_conf = 1'b0;
    check("rst_instruction", o_instruction, 16'h0);
    check("rst_output", o_output, 16'h0);
    check("rst_pc", o_pc, 4'h0);
    check("rst_flags", {o_flag_overflow, o_flag_zero}, 2'b00);
    check("rst_conflict", o_bus_conflict, 1'b0);
    #1;
    i_reset = 1'b0;
    @(posedge i_clock);
    #1;
  endtask

  initial begin
    int r;
    for (int i = 0; i < 16; i++) m_ram[i] = '0;
    do_reset();

    // Fill RAM so asynchronous reads are never unknown.
    host_write(4'd0, 16'h0105, 16'h0);
    for (int i = 1; i < 16; i++) host_write(4'(i), 16'($urandom), 16'h0);

    // Fetch through the bus.
    tick(bit_of(CTRL_PC_OUT) | bit_of(CTRL_MAR_IN));
    tick(bit_of(CTRL_RAM_OUT) | bit_of(CTRL_IR_IN) | bit_of(CTRL_PC_INC));
    check("t1_instruction", o_instruction, 16'h0105);
    check("t1_pc", o_pc, 4'd1);
    tick(bit_of(CTRL_PC_OUT) | bit_of(CTRL_MAR_IN));

    // Add with carry-out and zero result.
    put(16'hFFFF, CTRL_A_IN);
    put(16'h0001, CTRL_B_IN);
    tick(bit_of(CTRL_ALU_OUT) | bit_of(CTRL_A_IN) | bit_of(CTRL_FR_IN));
    check("t2_overflow", o_flag_overflow, 1'b1);
    check("t2_zero", o_flag_zero, 1'b1);
    tick(bit_of(CTRL_A_OUT) | bit_of(CTRL_OUT_IN));
    check("t2_a", o_output, 16'h0000);

    // Subtract with borrow.
    put(16'd5, CTRL_A_IN);
    put(16'd7, CTRL_B_IN);
    tick(bit_of(CTRL_ALU_SUB) | bit_of(CTRL_ALU_OUT) | bit_of(CTRL_A_IN) | bit_of(CTRL_FR_IN));
    check("t3_overflow", o_flag_overflow, 1'b0);
    check("t3_zero", o_flag_zero, 1'b0);
    tick(bit_of(CTRL_A_OUT) | bit_of(CTRL_OUT_IN));
    check("t3_a", o_output, 16'hFFFE);

    // PC wrap, then jump beats increment.
    put(16'h000F, CTRL_PC_JUMP);
    tick(bit_of(CTRL_PC_INC));
    check("t4_wrap", o_pc, 4'd0);
    put(16'h060A, CTRL_IR_IN);
    tick(bit_of(CTRL_IR_OUT) | bit_of(CTRL_PC_JUMP) | bit_of(CTRL_PC_INC));
    check("t4_jump", o_pc, 4'd10);

    // Two drivers: RAM wins over A, conflict is sticky.
    put(16'd3, CTRL_A_IN);
    host_write(m_mar, 16'd9, 16'h0);
    tick(bit_of(CTRL_A_OUT) | bit_of(CTRL_RAM_OUT));
    check("t5_bus", seen_bus, 16'd9);
    check("t5_conflict", o_bus_conflict, 1'b1);
    tick(16'h0);
    tick(bit_of(CTRL_HLT) | bit_of(CTRL_PC_INC));
    check("t5_sticky", o_bus_conflict, 1'b1);

    // Halt freezes A; reset mid-run keeps RAM.
    host_write(m_mar, 16'd4, 16'h0);
    tick(bit_of(CTRL_HLT) | bit_of(CTRL_RAM_OUT) | bit_of(CTRL_A_IN));
    tick(bit_of(CTRL_A_OUT) | bit_of(CTRL_OUT_IN));
    check("t6_halt_a", o_output, 16'd3);
    tick(bit_of(CTRL_PC_INC));
    do_reset();
    tick(bit_of(CTRL_RAM_OUT) | bit_of(CTRL_OUT_IN));
    check("t6_ram0", o_output, 16'h0105);

    // Randomized strobes, host writes and resets.
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        do_reset();
      end else if (r < 10) begin
        host_write(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
      end else begin
        logic [15:0] c;
        c = 16'($urandom & $urandom & $urandom);
        if ($urandom_range(0, 5) == 0) c[CTRL_HLT] = 1'b1;
        tick(c);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
